// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer plus four-state qualifier for a bouncing level input
module debounce_sync #(
   parameter int STABLE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic nq,
   output logic rise,
   output logic fall,
   output logic busy
);
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   localparam logic [15:0] LAST = 16'(STABLE - 1);
   state_t      state, state_nx;
   logic        s1, s2;
   logic [15:0] cnt, cnt_nx;
   logic        q_nx, rise_nx, fall_nx;
   // synchronizer and qualifier registers, all on the falling edge
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= IDLE_LOW;
         cnt   <= 16'd0;
         q     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1    <= din;
         s2    <= s1;
         state <= state_nx;
         cnt   <= cnt_nx;
         q     <= q_nx;
         rise  <= rise_nx;
         fall  <= fall_nx;
      end
   end
   // next state: a candidate level must hold for STABLE more samples to be accepted
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      q_nx     = q;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
         IDLE_LOW: if (s2) begin
            state_nx = WAIT_HIGH;
            cnt_nx   = 16'd0;
         end
         WAIT_HIGH: if (!s2) begin
            state_nx = IDLE_LOW;
            cnt_nx   = 16'd0;
         end else if (cnt == LAST) begin
            state_nx = IDLE_HIGH;
            cnt_nx   = 16'd0;
            q_nx     = 1'b1;
            rise_nx  = 1'b1;
         end else cnt_nx = cnt + 16'd1;
         IDLE_HIGH: if (!s2) begin
            state_nx = WAIT_LOW;
            cnt_nx   = 16'd0;
         end
         WAIT_LOW: if (s2) begin
            state_nx = IDLE_HIGH;
            cnt_nx   = 16'd0;
         end else if (cnt == LAST) begin
            state_nx = IDLE_LOW;
            cnt_nx   = 16'd0;
            q_nx     = 1'b0;
            fall_nx  = 1'b1;
         end else cnt_nx = cnt + 16'd1;
         default: state_nx = IDLE_LOW;
      endcase
   end
   assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);
   assign nq   = ~q;
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: random and directed stimulus on STABLE=4 and STABLE=1 instances against a run-length model
module tb_debounce_sync;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic din = 1'b0;
   logic q4, nq4, r4, f4, b4;
   logic q1, nq1, r1, f1, b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   stab [2] = '{4, 1};
   logic ms1 [2], ms2 [2], mq [2], mr [2], mf [2];
   int   run [2];

   debounce_sync #(.STABLE(4)) dut4 (.clk(clk), .rst(rst), .din(din), .q(q4), .nq(nq4), .rise(r4), .fall(f4), .busy(b4));
   debounce_sync #(.STABLE(1)) dut1 (.clk(clk), .rst(rst), .din(din), .q(q1), .nq(nq1), .rise(r1), .fall(f1), .busy(b1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ms1[i] = 0; ms2[i] = 0; mq[i] = 0; mr[i] = 0; mf[i] = 0; run[i] = 0;
      end
   endtask

   // output follows s2 once s2 has differed from q for STABLE+1 consecutive samples
   task automatic model_edge();
      logic v;
      for (int i = 0; i < 2; i++) begin
         v = ms2[i];
         ms2[i] = ms1[i];
         ms1[i] = din;
         mr[i] = 0;
         mf[i] = 0;
         run[i] = (v != mq[i]) ? run[i] + 1 : 0;
         if (run[i] == stab[i] + 1) begin
            mq[i] = ~mq[i];
            mr[i] = mq[i];
            mf[i] = ~mq[i];
            run[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      check("q4", q4, mq[0]);
      check("nq4", nq4, ~mq[0]);
      check("rise4", r4, mr[0]);
      check("fall4", f4, mf[0]);
      check("busy4", b4, run[0] > 0);
      check("q1", q1, mq[1]);
      check("nq1", nq1, ~mq[1]);
      check("rise1", r1, mr[1]);
      check("fall1", f1, mf[1]);
      check("busy1", b1, run[1] > 0);
   endtask

   task automatic step(input logic d, input int n);
      for (int k = 0; k < n; k++) begin
         din = d;
         @(negedge clk);
         if (!rst) model_reset();
         else model_edge();
         @(posedge clk);
         #1 check_all();
      end
   endtask

   initial begin
      model_reset();
      #1 check_all();
      @(posedge clk);
      #1 rst = 1'b1;
      step(0, 6);
      step(1, 12);
      step(0, 12);
      step(1, 3); step(0, 1); step(1, 12);
      step(0, 12);
      step(1, 2); step(0, 10);
      step(1, 1); step(0, 8);
      step(1, 3);
      #1 rst = 1'b0;
      #1 begin
         check("rst_q4", q4, 1'b0);
         check("rst_nq4", nq4, 1'b1);
         check("rst_busy4", b4, 1'b0);
         check("rst_rise4", r4, 1'b0);
         check("rst_q1", q1, 1'b0);
         check("rst_nq1", nq1, 1'b1);
      end
      model_reset();
      step(1, 2);
      rst = 1'b1;
      step(1, 10);
      step(0, 10);
      for (int s = 0; s < 60; s++) step(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      step(0, 10);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
